// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one 32-bit SRAM word port among NUM_REQ requesters.
// Define SRAM_ARB_TIMEOUT_EN to abort a transaction after TIMEOUT cycles without mem_done.
module sram_arbiter #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned ADDR_W  = 18,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        ack,
    output logic [NUM_REQ-1:0]        err,
    output logic [DATA_W-1:0]         rdata,
    output logic                      mem_req,
    output logic                      mem_wren,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [DATA_W-1:0]         mem_rdata,
    input  logic                      mem_done,
    output logic                      timeout_flag
);

    localparam int unsigned IdxW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e              state_q, state_d;
    logic [IdxW-1:0]     last_q, last_d;
    logic [IdxW-1:0]     win_q, win_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic                mem_wren_q, mem_wren_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic                found;
    logic [IdxW-1:0]     pick;

`ifdef SRAM_ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                err_q, err_d;
    logic                tflag_q, tflag_d;
`else
    logic                unused_timeout;
    assign unused_timeout = ^TIMEOUT;
`endif

    // Search from the requester after the last winner, wrapping around.
    always_comb begin
        logic [IdxW:0] sum;
        found = 1'b0;
        pick  = last_q;
        sum   = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            sum = {1'b0, last_q} + (IdxW + 1)'(i);
            if (sum >= (IdxW + 1)'(NUM_REQ)) begin
                sum = sum - (IdxW + 1)'(NUM_REQ);
            end
            if (!found && req[sum[IdxW-1:0]]) begin
                found = 1'b1;
                pick  = sum[IdxW-1:0];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        win_d       = win_q;
        gnt_d       = gnt_q;
        mem_wren_d  = mem_wren_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
`ifdef SRAM_ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
        err_d       = err_q;
        tflag_d     = tflag_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    win_d       = pick;
                    gnt_d       = NUM_REQ'(1'b1) << pick;
                    mem_wren_d  = req_we[pick];
                    mem_addr_d  = req_addr[32'(pick) * ADDR_W +: ADDR_W];
                    mem_wdata_d = req_wdata[32'(pick) * DATA_W +: DATA_W];
                    state_d     = StIssue;
                end
            end
            StIssue: begin
`ifdef SRAM_ARB_TIMEOUT_EN
                cnt_d = '0;
                err_d = 1'b0;
`endif
                state_d = StWait;
            end
            StWait: begin
                if (mem_done) begin
                    if (!mem_wren_q) begin
                        rdata_d = mem_rdata;
                    end
                    state_d = StResp;
`ifdef SRAM_ARB_TIMEOUT_EN
                end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                    // Counter reaches TIMEOUT this cycle with no completion.
                    err_d   = 1'b1;
                    tflag_d = 1'b1;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            StResp: begin
                gnt_d   = '0;
                last_d  = win_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            last_q      <= IdxW'(NUM_REQ - 1);
            win_q       <= '0;
            gnt_q       <= '0;
            mem_wren_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
`ifdef SRAM_ARB_TIMEOUT_EN
            cnt_q       <= '0;
            err_q       <= 1'b0;
            tflag_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            win_q       <= win_d;
            gnt_q       <= gnt_d;
            mem_wren_q  <= mem_wren_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
`ifdef SRAM_ARB_TIMEOUT_EN
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            tflag_q     <= tflag_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign ack       = (state_q == StResp) ? gnt_q : '0;
    assign mem_req   = (state_q == StIssue);
    assign mem_wren  = mem_wren_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign rdata     = rdata_q;
`ifdef SRAM_ARB_TIMEOUT_EN
    assign err          = (state_q == StResp && err_q) ? gnt_q : '0;
    assign timeout_flag = tflag_q;
`else
    assign err          = '0;
    assign timeout_flag = 1'b0;
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: transaction-level model checked every cycle plus directed
// scenarios with hand-computed expectations.
module tb_sram_arbiter;

    localparam int N  = 3;
    localparam int AW = 18;
    localparam int DW = 32;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    req_we = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N-1:0]    gnt, ack, err;
    logic [DW-1:0]   rdata;
    logic            mem_req, mem_wren;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata = '0;
    logic            mem_done = 1'b0;
    logic            timeout_flag;

    sram_arbiter #(
        .NUM_REQ(N),
        .ADDR_W (AW),
        .DATA_W (DW),
        .TIMEOUT(TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .gnt         (gnt),
        .ack         (ack),
        .err         (err),
        .rdata       (rdata),
        .mem_req     (mem_req),
        .mem_wren    (mem_wren),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_done    (mem_done),
        .timeout_flag(timeout_flag)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // SRAM block stand-in: done pulses 'delay' cycles after mem_req (0 = never).
    int            delay = 0;
    int            ctr = 0;
    logic          force_done = 1'b0;
    logic [DW-1:0] resp_data = '0;

    initial forever begin
        @(negedge clk);
        #1;
        mem_done = force_done;
        if (!rst_n) begin
            ctr = 0;
        end else begin
            if (ctr > 0) begin
                ctr--;
                if (ctr == 0) begin
                    mem_done  = 1'b1;
                    mem_rdata = resp_data;
                end
            end
            if (mem_req && delay > 0) ctr = delay;
        end
    end

    // Transaction model: one job at a time, age counts edges since grant.
    logic          busy, resp, m_err, m_tflag, m_wren;
    int            win, last, age;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;

    task automatic model_step();
        bit found;
        if (!rst_n) begin
            busy = 0; resp = 0; m_err = 0; m_tflag = 0; m_wren = 0;
            win = 0; last = N - 1; age = 0;
            m_addr = '0; m_wdata = '0; m_rdata = '0;
        end else if (!busy) begin
            found = 0;
            for (int k = 1; k <= N; k++) begin
                if (!found && req[(last + k) % N]) begin
                    found = 1;
                    win   = (last + k) % N;
                end
            end
            if (found) begin
                busy = 1; resp = 0; m_err = 0; age = 0;
                m_wren  = req_we[win];
                m_addr  = req_addr[win*AW +: AW];
                m_wdata = req_wdata[win*DW +: DW];
            end
        end else if (resp) begin
            busy = 0; resp = 0; last = win;
        end else begin
            age++;
            if (age >= 2) begin
                if (mem_done) begin
                    resp = 1;
                    if (!m_wren) m_rdata = mem_rdata;
                end
`ifdef SRAM_ARB_TIMEOUT_EN
                else if (age - 1 == TO) begin
                    resp = 1; m_err = 1; m_tflag = 1;
                end
`endif
            end
        end
    endtask

    initial begin
        model_step();
        forever begin
            @(posedge clk or negedge rst_n);
            model_step();
        end
    end

    bit cmp_on = 1;

    initial forever begin
        logic [N-1:0] oh;
        @(posedge clk);
        #1;
        if (cmp_on) begin
            oh = busy ? (N'(1) << win) : '0;
            chk("gnt", gnt, oh);
            chk("ack", ack, resp ? oh : '0);
            chk("err", err, (resp && m_err) ? oh : '0);
            chk("mem_req", mem_req, busy && age == 0 && !resp);
            chk("mem_wren", mem_wren, m_wren);
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_wdata", mem_wdata, m_wdata);
            chk("rdata", rdata, m_rdata);
            chk("timeout_flag", timeout_flag, m_tflag);
        end
    end

    task automatic wait_ack(input logic [N-1:0] mask, input int maxc,
                            output int cyc, output logic [N-1:0] seen);
        cyc  = 0;
        seen = '0;
        while (cyc < maxc) begin
            @(posedge clk);
            #1;
            cyc++;
            if ((ack & mask) != '0) begin
                seen = ack;
                return;
            end
        end
        tests++;
        fails++;
        $display("FAIL ack_wait: no ack after %0d cycles, required within %0d", cyc, maxc);
    endtask

    task automatic chk_zero(input string pfx);
        chk({pfx, "_gnt"}, gnt, 0);
        chk({pfx, "_ack"}, ack, 0);
        chk({pfx, "_err"}, err, 0);
        chk({pfx, "_rdata"}, rdata, 0);
        chk({pfx, "_mem_req"}, mem_req, 0);
        chk({pfx, "_mem_wren"}, mem_wren, 0);
        chk({pfx, "_mem_addr"}, mem_addr, 0);
        chk({pfx, "_mem_wdata"}, mem_wdata, 0);
        chk({pfx, "_tflag"}, timeout_flag, 0);
    endtask

    task automatic do_reset(input string pfx);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_zero(pfx);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int            c;
    logic [N-1:0]  s;
    logic [N-1:0]  exp_order [4];

    initial begin
        exp_order[0] = 3'b001; exp_order[1] = 3'b010;
        exp_order[2] = 3'b100; exp_order[3] = 3'b001;

        repeat (2) @(negedge clk);
        #1;
        chk_zero("rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single read, done in the second WAIT cycle
        delay = 2; resp_data = 32'h80F02040;
        req_addr[0*AW +: AW] = 18'h00010; req_we[0] = 1'b0; req = 3'b001;
        wait_ack(3'b001, 20, c, s);
        chk("rd_latency", c, 4);
        chk("rd_ack", s, 3'b001);
        chk("rd_gnt", gnt, 3'b001);
        chk("rd_rdata", rdata, 32'h80F02040);
        chk("rd_addr", mem_addr, 18'h00010);
        chk("rd_wren", mem_wren, 0);
        @(negedge clk); req = '0;
        @(negedge clk);

        // Single write on requester 1; rdata must not move
        delay = 3; resp_data = 32'h11111111;
        req_addr[1*AW +: AW] = 18'h3FFFF; req_wdata[1*DW +: DW] = 32'hDEADBEEF;
        req_we[1] = 1'b1; req = 3'b010;
        wait_ack(3'b010, 20, c, s);
        chk("wr_latency", c, 5);
        chk("wr_ack", s, 3'b010);
        chk("wr_wren", mem_wren, 1);
        chk("wr_wdata", mem_wdata, 32'hDEADBEEF);
        chk("wr_addr", mem_addr, 18'h3FFFF);
        chk("wr_rdata", rdata, 32'h80F02040);
        @(negedge clk); req = '0;

        // Rotation from reset with all requesters held
        do_reset("rst2");
        delay = 1; resp_data = 32'hA5A50000; req_we = '0;
        req_addr = {18'h00003, 18'h00002, 18'h00001};
        req = 3'b111;
        for (int k = 0; k < 4; k++) begin
            wait_ack(3'b111, 10, c, s);
            chk($sformatf("rot%0d_ack", k), s, exp_order[k]);
            chk($sformatf("rot%0d_gap", k), c, (k == 0) ? 3 : 4);
        end
        @(negedge clk); req = '0;
        @(negedge clk);

        // Stale done in IDLE/ISSUE, late addr change, req drop after grant, short pulse
        delay = 3; req_addr[0*AW +: AW] = 18'h00155; req = 3'b001; force_done = 1'b1;
        @(negedge clk);
        req_addr[0*AW +: AW] = 18'h002AA; req[2] = 1'b1;
        @(negedge clk);
        force_done = 1'b0; req = '0;
        wait_ack(3'b111, 10, c, s);
        chk("stale_latency", c, 3);
        chk("stale_ack", s, 3'b001);
        chk("stale_addr", mem_addr, 18'h00155);
        repeat (8) @(posedge clk);
        #1;
        chk("pulse_gnt", gnt, 0);

        // Reset while in WAIT
        @(negedge clk);
        delay = 5; req = 3'b001;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1; delay = 1; req = 3'b111;
        wait_ack(3'b111, 10, c, s);
        chk("midrst_first", s, 3'b001);
        @(negedge clk); req = '0;
        @(negedge clk);

        // No mem_done at all
        delay = 0; req_we[1] = 1'b0; req = 3'b010;
`ifdef SRAM_ARB_TIMEOUT_EN
        wait_ack(3'b010, 20, c, s);
        chk("to_latency", c, TO + 2);
        chk("to_err", err, 3'b010);
        chk("to_flag", timeout_flag, 1);
        @(negedge clk); req = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("to_flag_sticky", timeout_flag, 1);
`else
        repeat (20) @(posedge clk);
        #1;
        chk("nodone_gnt", gnt, 3'b010);
        chk("nodone_ack", ack, 0);
        chk("nodone_err", err, 0);
        chk("nodone_flag", timeout_flag, 0);
        @(negedge clk); req = '0;
        do_reset("rst3");
`endif
        repeat (2) @(posedge clk);
        #2;
        cmp_on = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
